snake_body_ctrl: RTL and testbench

Snake body manager that acts as the sole master of the 64x8 body RAM (`mem`). It keeps the snake as a circular list of 8-bit cell positions in that RAM and, on each move tick, writes the new head. It also serves single-segment lookups to the renderer and, optionally, checks whether the new head overlaps the body. It sits between the game-logic FSM (tick, direction, grow) and `mem`, driving the RAM's read_rq/write_rq/rw_address/write_data and sampling read_data.

---
 rtl/snake_body_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : snake_body_ctrl                                                |
// | Desc     : Snake body manager; sole master of the 64x8 body RAM. Keeps    |
// |            the snake as a circular list, writes new heads, serves        |
// |            segment lookups. Optional self-collision check: SELF_HIT_EN.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module snake_body_ctrl #(
    parameter int          INIT_LEN  = 3,
    parameter logic [7:0]  INIT_HEAD = 8'h88
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [1:0]  dir,
    input  logic        grow,
    input  logic        scan_req,
    input  logic [5:0]  scan_idx,
    output logic        scan_valid,
    output logic [7:0]  scan_pos,
    output logic        busy,
    output logic [6:0]  length,
    output logic [7:0]  head_pos,
    output logic        full,
    output logic        hit,
    output logic        mem_read_rq,
    output logic        mem_write_rq,
    output logic [5:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_SCAN  = 3'd3
`ifdef SELF_HIT_EN
        ,
        S_CHECK = 3'd4
`endif
    } state_t;

    localparam logic [5:0] c_LAST_INIT = 6'(INIT_LEN - 1);
    localparam logic [6:0] c_MAX_LEN   = 7'd64;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_head_ptr;
    logic [6:0]  r_length;
    logic [7:0]  r_head_pos;
    logic [7:0]  r_new_pos;
    logic        r_grow;
    logic [5:0]  r_scan_idx;
    logic        r_scan_valid;
    logic [7:0]  r_scan_pos;
    logic        r_full;
`ifdef SELF_HIT_EN
    logic [5:0]  r_k;
    logic        r_hit;
`endif

    logic [5:0]  w_init_off;
    logic [3:0]  w_init_x;
    logic [3:0]  w_nx;
    logic [3:0]  w_ny;
    logic [7:0]  w_next_pos;
    logic [6:0]  w_len_next;
    logic        w_scan_in_range;

    // Initial body lies to the left of the head, tail in slot 0.
    assign w_init_off      = c_LAST_INIT - r_cnt;
    assign w_init_x        = INIT_HEAD[3:0] - w_init_off[3:0];
    assign w_len_next      = (r_grow && (r_length != c_MAX_LEN)) ? r_length + 7'd1 : r_length;
    assign w_scan_in_range = ({1'b0, r_scan_idx} < r_length);

    always_comb begin
        w_nx = r_head_pos[3:0];
        w_ny = r_head_pos[7:4];
        case (dir)
            2'd0:    w_ny = r_head_pos[7:4] - 4'd1;
            2'd1:    w_nx = r_head_pos[3:0] + 4'd1;
            2'd2:    w_ny = r_head_pos[7:4] + 4'd1;
            default: w_nx = r_head_pos[3:0] - 4'd1;
        endcase
        w_next_pos = {w_ny, w_nx};
    end

    // RAM strobes decode from registered state; rst gating keeps them low
    // while the reset is held even though the state already reads INIT.
    always_comb begin
        mem_read_rq  = 1'b0;
        mem_write_rq = 1'b0;
        mem_addr     = 6'd0;
        mem_wdata    = 8'd0;
        if (rst) begin
            case (r_state)
                S_INIT: begin
                    mem_write_rq = 1'b1;
                    mem_addr     = r_cnt;
                    mem_wdata    = {INIT_HEAD[7:4], w_init_x};
                end
                S_WRITE: begin
                    mem_write_rq = 1'b1;
                    mem_addr     = r_head_ptr + 6'd1;
                    mem_wdata    = r_new_pos;
                end
                S_SCAN: begin
                    if (w_scan_in_range) begin
                        mem_read_rq = 1'b1;
                        mem_addr    = r_head_ptr - r_scan_idx;
                    end
                end
`ifdef SELF_HIT_EN
                S_CHECK: begin
                    mem_read_rq = 1'b1;
                    mem_addr    = r_head_ptr - r_k;
                end
`endif
                default: begin
                    mem_read_rq  = 1'b0;
                    mem_write_rq = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_cnt        <= 6'd0;
            r_head_ptr   <= 6'd0;
            r_length     <= 7'd0;
            r_head_pos   <= 8'd0;
            r_new_pos    <= 8'd0;
            r_grow       <= 1'b0;
            r_scan_idx   <= 6'd0;
            r_scan_valid <= 1'b0;
            r_scan_pos   <= 8'd0;
            r_full       <= 1'b0;
`ifdef SELF_HIT_EN
            r_k          <= 6'd0;
            r_hit        <= 1'b0;
`endif
        end else begin
            r_scan_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_cnt == c_LAST_INIT) begin
                        r_head_ptr <= c_LAST_INIT;
                        r_length   <= 7'(INIT_LEN);
                        r_head_pos <= INIT_HEAD;
                        r_full     <= (INIT_LEN == 64);
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_IDLE: begin
                    // A simultaneous scan request is dropped in favour of the move.
                    if (step) begin
                        r_new_pos <= w_next_pos;
                        r_grow    <= grow;
                        r_state   <= S_WRITE;
                    end else if (scan_req) begin
                        r_scan_idx <= scan_idx;
                        r_state    <= S_SCAN;
                    end
                end
                S_WRITE: begin
                    r_head_ptr <= r_head_ptr + 6'd1;
                    r_head_pos <= r_new_pos;
                    r_length   <= w_len_next;
                    r_full     <= (w_len_next == c_MAX_LEN);
`ifdef SELF_HIT_EN
                    if (w_len_next > 7'd1) begin
                        r_k     <= 6'd1;
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state    <= S_IDLE;
`endif
                end
`ifdef SELF_HIT_EN
                S_CHECK: begin
                    if (mem_rdata == r_head_pos) begin
                        r_hit <= 1'b1;
                    end
                    if ({1'b0, r_k} == (r_length - 7'd1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= r_k + 6'd1;
                    end
                end
`endif
                S_SCAN: begin
                    r_scan_pos   <= w_scan_in_range ? mem_rdata : 8'hFF;
                    r_scan_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign length     = r_length;
    assign head_pos   = r_head_pos;
    assign full       = r_full;
    assign scan_valid = r_scan_valid;
    assign scan_pos   = r_scan_pos;
`ifdef SELF_HIT_EN
    assign hit        = r_hit;
`else
    assign hit        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_snake_body_ctrl                                             |
// | Desc     : Self-checking bench for snake_body_ctrl with a 64x8 RAM model   |
// |            and a body-list reference model.                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_snake_body_ctrl;

`ifdef SELF_HIT_EN
    localparam logic c_HIT_EN = 1'b1;
`else
    localparam logic c_HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic        grow = 1'b0;
    logic        scan_req = 1'b0;
    logic [5:0]  scan_idx = 6'd0;
    logic        scan_valid;
    logic [7:0]  scan_pos;
    logic        busy;
    logic [6:0]  length;
    logic [7:0]  head_pos;
    logic        full;
    logic        hit;
    logic        mem_read_rq;
    logic        mem_write_rq;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [64];
    logic [7:0]  sb [$];
    logic [7:0]  m_body [$];
    int          m_len;
    logic        m_hit;
    int          n_checks = 0;
    int          n_errors = 0;
    int          valid_cnt = 0;

    always #5 clk = ~clk;

    snake_body_ctrl #(.INIT_LEN(3), .INIT_HEAD(8'h88)) dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
        .scan_req(scan_req), .scan_idx(scan_idx), .scan_valid(scan_valid),
        .scan_pos(scan_pos), .busy(busy), .length(length), .head_pos(head_pos),
        .full(full), .hit(hit), .mem_read_rq(mem_read_rq), .mem_write_rq(mem_write_rq),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'd0;
        end else if (mem_write_rq) begin
            ram[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rw_excl", 32'(mem_read_rq & mem_write_rq), 32'd0);
        if (rst && scan_valid) begin
            valid_cnt++;
            check("scan_sb", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("scan_pos", 32'(scan_pos), 32'(sb.pop_front()));
        end
    end

    function automatic logic [7:0] next_pos(input logic [7:0] p, input logic [1:0] d);
        logic [3:0] x, y;
        x = p[3:0];
        y = p[7:4];
        if (d == 2'd0) y = y - 4'd1;
        else if (d == 2'd1) x = x + 4'd1;
        else if (d == 2'd2) y = y + 4'd1;
        else x = x - 4'd1;
        return {y, x};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        int n = 0;
        @(negedge clk);
        rst = 1'b0; step = 1'b0; scan_req = 1'b0; grow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy), 32'd1);
        check("rst_len",    32'(length), 32'd0);
        check("rst_head",   32'(head_pos), 32'd0);
        check("rst_full",   32'(full), 32'd0);
        check("rst_hit",    32'(hit), 32'd0);
        check("rst_svalid", 32'(scan_valid), 32'd0);
        check("rst_spos",   32'(scan_pos), 32'd0);
        check("rst_mem",    {mem_read_rq, mem_write_rq, mem_addr, mem_wdata}, 32'd0);
        sb.delete();
        m_body = '{8'h88, 8'h87, 8'h86};
        m_len  = 3;
        m_hit  = 1'b0;
        rst = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        check("init_cycles", 32'(n), 32'd3);
        check("init_slot0", 32'(ram[0]), 32'h86);
        check("init_slot1", 32'(ram[1]), 32'h87);
        check("init_slot2", 32'(ram[2]), 32'h88);
        check("init_len",   32'(length), 32'd3);
        check("init_head",  32'(head_pos), 32'h88);
        check("init_hit",   32'(hit), 32'd0);
    endtask

    task automatic do_step(input logic [1:0] d, input logic g, input logic with_scan);
        logic [7:0] np;
        int n, vc, extra;
        wait_idle();
        vc = valid_cnt;
        dir = d; grow = g; step = 1'b1; scan_req = with_scan; scan_idx = 6'd0;
        @(posedge clk);
        #1 step = 1'b0; grow = 1'b0; scan_req = 1'b0;
        np = next_pos(m_body[0], d);
        m_body.push_front(np);
        if (g && m_len < 64) m_len++;
        while (m_body.size() > m_len) void'(m_body.pop_back());
        for (int k = 1; k < m_len; k++) if (c_HIT_EN && m_body[k] == np) m_hit = 1'b1;
        extra = c_HIT_EN ? m_len - 1 : 0;
        @(negedge clk);
        check("step_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("step_head", 32'(head_pos), 32'(np));
        check("step_len",  32'(length), 32'(m_len));
        check("step_full", 32'(full), 32'(m_len == 64));
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("step_lat", 32'(n), 32'(extra));
        check("step_hit", 32'(hit), 32'(m_hit));
        if (with_scan) begin
            repeat (3) @(negedge clk);
            check("both_novalid", 32'(valid_cnt - vc), 32'd0);
        end
    endtask

    task automatic do_scan(input logic [5:0] idx);
        wait_idle();
        sb.push_back((idx < m_len) ? m_body[idx] : 8'hFF);
        scan_idx = idx; scan_req = 1'b1;
        @(posedge clk);
        #1 scan_req = 1'b0;
        @(negedge clk);
        check("scan_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1 check("scan_lat", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 4; i++) do_scan(6'(i));

        do_step(2'd1, 1'b0, 1'b0);
        check("slot3", 32'(ram[3]), 32'h89);
        for (int i = 0; i < 4; i++) do_scan(6'(i));

        for (int i = 0; i < 7; i++) do_step(2'd1, 1'b0, 1'b0);
        check("wrap_x", 32'(head_pos), 32'h80);

        for (int i = 0; i < 61; i++) do_step(2'd1, 1'b1, 1'b0);
        check("full_len", 32'(length), 32'd64);
        check("full_flag", 32'(full), 32'd1);
        do_scan(6'd0); do_scan(6'd1); do_scan(6'd2); do_scan(6'd62); do_scan(6'd63);
        do_step(2'd2, 1'b1, 1'b0);
        check("full_hold", 32'(length), 32'd64);
        do_scan(6'd63);
        do_step(2'd2, 1'b0, 1'b1);

        do_reset();
        do_step(2'd1, 1'b1, 1'b0);
        do_step(2'd1, 1'b1, 1'b0);
        do_step(2'd1, 1'b0, 1'b0);
        do_step(2'd2, 1'b0, 1'b0);
        do_step(2'd3, 1'b0, 1'b0);
        do_step(2'd0, 1'b0, 1'b0);
        check("hit_final", 32'(hit), 32'(c_HIT_EN));

        wait_idle();
        dir = 2'd2; step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(posedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            do_scan(6'($urandom_range(0, 7)));
        end

        wait_idle();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
